// File: rtl/util_timestamp_pkg.sv
// util_timestamp_pkg
// Constants and types shared by the RX timestamp packer and the TX timestamp gate.
package util_timestamp_pkg;

    localparam int TIMESTAMP_WIDTH = 64;

    // Header word that opens every timestamped frame ("TIMESTMP" in ASCII).
    localparam logic [TIMESTAMP_WIDTH-1:0] TIMESTAMP_MAGIC = 64'h504D5453454D4954;

    // Framing states of the TX gate.
    typedef enum logic [2:0] {
        GATE_HEADER    = 3'd0,
        GATE_TS_VALUE  = 3'd1,
        GATE_WAIT_TIME = 3'd2,
        GATE_STREAM    = 3'd3,
        GATE_DROP      = 3'd4
    } gate_state_t;

endpackage

// File: rtl/util_sat_counter.sv
// util_sat_counter
// Up-counter that sticks at all-ones instead of wrapping; clear has priority.
module util_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count events, hold at the ceiling.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/util_upack2_timestamp_gate.sv
// util_upack2_timestamp_gate
// TX-side timestamp gate between the TX DMA and the TX unpacker. Parses
// frames of MAGIC header, target timestamp, then words_per_packet payload
// words, and holds each payload until the sample timestamp reaches its target.
// words_per_packet == 0 selects a zero-latency bypass.
// Build macro UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN: when defined, frames whose
// target has already passed are consumed and discarded; otherwise they are
// released immediately. late_count increments in both builds.
module util_upack2_timestamp_gate
    import util_timestamp_pkg::*;
#(
    parameter logic [TIMESTAMP_WIDTH-1:0] MAGIC       = TIMESTAMP_MAGIC,
    parameter int                         COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [TIMESTAMP_WIDTH-1:0] timestamp,
    input  logic [31:0]                words_per_packet,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [63:0]                in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [63:0]                out_data,
    output logic [COUNT_WIDTH-1:0]     late_count,
    output logic [COUNT_WIDTH-1:0]     sync_error_count,
    output logic                       waiting
);

`ifdef UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN
    localparam gate_state_t LATE_NEXT = GATE_DROP;
`else
    localparam gate_state_t LATE_NEXT = GATE_STREAM;
`endif

    gate_state_t                state;
    logic [31:0]                word_cnt;
    logic [31:0]                wpp_latched;
    logic [TIMESTAMP_WIDTH-1:0] target;

    logic bypass;
    logic xfer;
    logic is_magic;
    logic is_late;
    logic last_word;
    logic sync_inc;
    logic late_inc;

    assign bypass    = (words_per_packet == 32'd0);
    assign xfer      = in_valid && in_ready;
    assign is_magic  = (in_data == MAGIC);
    // Unsigned compare: a target equal to the current time is on time.
    assign is_late   = (timestamp > in_data);
    assign last_word = (word_cnt == (wpp_latched - 32'd1));
    assign sync_inc  = (state == GATE_HEADER) && !bypass && xfer && !is_magic;
    assign late_inc  = (state == GATE_TS_VALUE) && xfer && is_late;

    // Payload is never buffered, so the output word is always the input word.
    assign out_data = in_data;

    // Handshake steering per state; everything is forced idle during reset.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        waiting   = 1'b0;
        if (!reset) begin
            case (state)
                GATE_HEADER: begin
                    if (bypass) begin
                        out_valid = in_valid;
                        in_ready  = out_ready;
                    end else begin
                        in_ready = 1'b1;
                    end
                end
                GATE_TS_VALUE:  in_ready = 1'b1;
                GATE_WAIT_TIME: waiting  = 1'b1;
                GATE_STREAM: begin
                    out_valid = in_valid;
                    in_ready  = out_ready;
                end
                GATE_DROP:      in_ready = 1'b1;
                default: begin
                    in_ready  = 1'b0;
                    out_valid = 1'b0;
                end
            endcase
        end
    end

    // Framing state machine and payload word counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= GATE_HEADER;
            word_cnt <= 32'd0;
        end else begin
            case (state)
                GATE_HEADER: begin
                    if (!bypass && xfer && is_magic) begin
                        state <= GATE_TS_VALUE;
                    end
                end
                GATE_TS_VALUE: begin
                    if (xfer) begin
                        state <= is_late ? LATE_NEXT : GATE_WAIT_TIME;
                    end
                end
                GATE_WAIT_TIME: begin
                    if (timestamp >= target) begin
                        state <= GATE_STREAM;
                    end
                end
                GATE_STREAM, GATE_DROP: begin
                    if (xfer) begin
                        if (last_word) begin
                            word_cnt <= 32'd0;
                            state    <= GATE_HEADER;
                        end else begin
                            word_cnt <= word_cnt + 32'd1;
                        end
                    end
                end
                default: begin
                    state    <= GATE_HEADER;
                    word_cnt <= 32'd0;
                end
            endcase
        end
    end

    // Frame length is frozen at header acceptance; target time at its word.
    always_ff @(posedge clk) begin
        if ((state == GATE_HEADER) && !bypass && xfer && is_magic) begin
            wpp_latched <= words_per_packet;
        end
        if ((state == GATE_TS_VALUE) && xfer) begin
            target <= in_data;
        end
    end

    // Status counter: frames that arrived after their target time.
    util_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_late_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (late_inc),
        .count (late_count)
    );

    // Status counter: non-header words seen while hunting for MAGIC.
    util_sat_counter #(
        .WIDTH (COUNT_WIDTH)
    ) u_sync_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (sync_inc),
        .count (sync_error_count)
    );

endmodule

// File: tb/tb_util_upack2_timestamp_gate.sv
// tb_util_upack2_timestamp_gate
// Frame-level reference model checked against the gate every cycle, plus
// directed scenarios with hand-derived expectations and a randomized phase.
module tb_util_upack2_timestamp_gate;

    localparam int          CW      = 4;
    localparam int          SAT     = (1 << CW) - 1;
    localparam logic [63:0] MAGIC_W = 64'h504D5453454D4954;
`ifdef UTIL_UPACK2_TIMESTAMP_LATE_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic          clk              = 1'b0;
    logic          reset            = 1'b1;
    logic [63:0]   timestamp        = 64'd0;
    logic [31:0]   words_per_packet = 32'd0;
    logic          in_valid         = 1'b0;
    logic [63:0]   in_data          = 64'd0;
    logic          out_ready        = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic          waiting;
    logic [63:0]   out_data;
    logic [CW-1:0] late_count;
    logic [CW-1:0] sync_error_count;

    always #5 clk = ~clk;

    util_upack2_timestamp_gate #(
        .COUNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .timestamp        (timestamp),
        .words_per_packet (words_per_packet),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .late_count       (late_count),
        .sync_error_count (sync_error_count),
        .waiting          (waiting)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] src_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] log_data[$];
    logic [63:0] log_ts[$];
    logic [63:0] last_wait_ts = 64'd0;
    bit          acc          = 1'b0;
    int          ready_mode   = 0;
    bit          gap_en       = 1'b0;
    bit          ts_rand      = 1'b0;
    int          cyc          = 0;

    // Reference model: where we are inside the current frame.
    bit              m_hdr    = 1'b0;
    bit              m_tsok   = 1'b0;
    bit              m_rel    = 1'b0;
    bit              m_drop   = 1'b0;
    logic [31:0]     m_wpp    = 32'd0;
    logic [63:0]     m_target = 64'd0;
    longint unsigned m_left   = 0;
    int              m_late   = 0;
    int              m_sync   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison, then advance the model by what the edge will do.
    always @(negedge clk) begin
        bit e_ir;
        bit e_ov;
        bit e_w;
        bit e_acc;
        e_ir = 1'b0;
        e_ov = 1'b0;
        e_w  = 1'b0;
        if (!reset) begin
            if (!m_hdr) begin
                if (words_per_packet == 32'd0) begin
                    e_ov = in_valid;
                    e_ir = out_ready;
                end else begin
                    e_ir = 1'b1;
                end
            end else if (!m_tsok) begin
                e_ir = 1'b1;
            end else if (!m_rel) begin
                e_w = 1'b1;
            end else if (m_drop) begin
                e_ir = 1'b1;
            end else begin
                e_ov = in_valid;
                e_ir = out_ready;
            end
        end
        check("in_ready", in_ready, e_ir);
        check("out_valid", out_valid, e_ov);
        check("waiting", waiting, e_w);
        if (e_ov) check("out_data", out_data, in_data);
        check("late_count", late_count, m_late);
        check("sync_error_count", sync_error_count, m_sync);

        if (waiting) last_wait_ts = timestamp;
        if (out_valid && out_ready) begin
            log_data.push_back(out_data);
            log_ts.push_back(timestamp);
        end
        acc   = in_valid && in_ready;
        e_acc = in_valid && e_ir;

        if (reset) begin
            m_hdr = 0; m_tsok = 0; m_rel = 0; m_drop = 0; m_left = 0;
            m_late = 0; m_sync = 0;
        end else if (!m_hdr) begin
            if (words_per_packet != 32'd0 && e_acc) begin
                if (in_data == MAGIC_W) begin
                    m_hdr = 1;
                    m_wpp = words_per_packet;
                end else if (m_sync < SAT) begin
                    m_sync++;
                end
            end
        end else if (!m_tsok) begin
            if (e_acc) begin
                m_tsok   = 1;
                m_target = in_data;
                m_left   = m_wpp;
                if (timestamp > in_data) begin
                    if (m_late < SAT) m_late++;
                    m_rel  = 1;
                    m_drop = DROP_EN;
                end
            end
        end else if (!m_rel) begin
            if (timestamp >= m_target) m_rel = 1;
        end else if (e_acc) begin
            m_left--;
            if (m_left == 0) begin
                m_hdr = 0; m_tsok = 0; m_rel = 0; m_drop = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (acc && src_q.size() != 0) void'(src_q.pop_front());
        if (ts_rand) timestamp = timestamp + 64'($urandom_range(0, 2));
        else         timestamp = timestamp + 64'd1;
        in_valid = (src_q.size() != 0) && !(gap_en && $urandom_range(0, 3) == 0);
        in_data  = (src_q.size() != 0) ? src_q[0] : {$urandom, $urandom};
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        endcase
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while (src_q.size() != 0 && n < max_cyc) begin
            step();
            n++;
        end
        check("drain_done", 64'(src_q.size()), 64'd0);
        repeat (3) step();
    endtask

    task automatic push_frame(input logic [63:0] tgt, input int nw);
        logic [63:0] w;
        src_q.push_back(MAGIC_W);
        src_q.push_back(tgt);
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            src_q.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic check_log(input string nm, input int n_exp);
        check({nm, "_count"}, 64'(log_data.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < log_data.size() && i < exp_q.size(); i++)
            check({nm, "_data"}, log_data[i], exp_q[i]);
    endtask

    task automatic clear_logs();
        exp_q.delete();
        log_data.delete();
        log_ts.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] tgt;
        logic [63:0] w;
        int          n;
        int          wr;

        // Reset holds every handshake low even with bypass traffic offered.
        repeat (3) step();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_waiting", waiting, 0);
        step();
        reset = 1'b0;
        step();
        check("rst_late_count", late_count, 0);
        check("rst_sync_count", sync_error_count, 0);

        // Bypass: zero-latency pass-through.
        clear_logs();
        words_per_packet = 32'd0;
        for (int i = 0; i < 8; i++) begin
            w = {$urandom, $urandom};
            src_q.push_back(w);
            exp_q.push_back(w);
        end
        drain(50);
        check_log("bypass", 8);
        check("bypass_sync", sync_error_count, 0);

        // Normal frame released when timestamp reaches 150.
        clear_logs();
        words_per_packet = 32'd4;
        timestamp        = 64'd100;
        push_frame(64'd150, 4);
        drain(200);
        check_log("normal", 4);
        check("normal_first_ts", (log_ts.size() > 0) ? log_ts[0] : '1, 64'd151);
        check("normal_last_ts", (log_ts.size() > 3) ? log_ts[3] : '1, 64'd154);
        check("normal_last_wait", last_wait_ts, 64'd150);
        check("normal_late", late_count, 0);

        // Late frame.
        clear_logs();
        timestamp = 64'd500;
        push_frame(64'd200, 4);
        drain(100);
        check("late_count_1", late_count, 1);
        check("late_out_count", 64'(log_data.size()), DROP_EN ? 64'd0 : 64'd4);

        // Three junk words, then a good frame.
        clear_logs();
        for (int i = 0; i < 3; i++) src_q.push_back({32'hBAD00000 | 32'(i), $urandom});
        tgt = timestamp + 64'd20;
        push_frame(tgt, 4);
        drain(100);
        check("sync_count_3", sync_error_count, 3);
        check_log("after_sync", 4);
        check("after_sync_first_ts", (log_ts.size() > 0) ? log_ts[0] : '1, tgt + 64'd1);

        // Backpressure 1-0-0-1 during streaming.
        clear_logs();
        ready_mode = 2;
        push_frame(timestamp + 64'd10, 4);
        drain(100);
        check_log("backpressure", 4);
        ready_mode = 0;

        // Target equal to now, then reset after two payload words.
        clear_logs();
        ts_rand = 1'b1;
        timestamp = timestamp + 64'd5;
        push_frame(timestamp + 64'd2, 4);
        n = 0;
        while (log_data.size() < 2 && n < 100) begin
            step();
            n++;
        end
        check("midrst_reached", 64'(log_data.size()), 64'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_late_clear", late_count, 0);
        check("midrst_sync_clear", sync_error_count, 0);
        drain(50);
        check("midrst_sync_2", sync_error_count, 2);
        check_log("midrst", 2);
        ts_rand = 1'b0;

        // Sync error counter saturates.
        for (int i = 0; i < 20; i++) src_q.push_back({32'hBAD10000 | 32'(i), $urandom});
        drain(100);
        check("sync_saturated", sync_error_count, SAT);

        // Randomized traffic.
        ready_mode = 1;
        gap_en     = 1'b1;
        ts_rand    = 1'b1;
        timestamp  = timestamp + 64'd1000;
        for (int f = 0; f < 40; f++) begin
            clear_logs();
            if ($urandom_range(0, 9) == 0) begin
                words_per_packet = 32'd0;
                repeat ($urandom_range(1, 4)) src_q.push_back({$urandom, $urandom});
                drain(200);
            end else begin
                wr = $urandom_range(1, 5);
                words_per_packet = 32'(wr);
                repeat ($urandom_range(0, 2)) src_q.push_back({32'hBAD20000, $urandom});
                tgt = timestamp + 64'($urandom_range(0, 40)) - 64'd10;
                push_frame(tgt, wr);
                n = 0;
                while (src_q.size() != 0 && n < 2000) begin
                    if (src_q.size() <= wr && $urandom_range(0, 7) == 0)
                        words_per_packet = 32'($urandom_range(0, 7));
                    step();
                    n++;
                end
                check("rand_drain", 64'(src_q.size()), 64'd0);
                repeat (3) step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
